// File: rtl/tcam_add32_seq_ctrl_if.sv
// Request/response bus between a client and the TCAM ripple-add sequencer.
// Handshake: a transfer occurs on a rising clk edge where valid && ready; the
// sender holds valid and its payload stable until that edge, and ready never waits on valid.
interface tcam_add32_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_cin;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;
  logic             rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_err
  );
endinterface

// File: rtl/tcam_add32_seq_ctrl.sv
// Sequences a WIDTH-bit ripple add through one shared 4-bit TCAM adder slice,
// LSB nibble first, chaining the carry and flagging slice timeouts/errors.
module tcam_add32_seq_ctrl #(
  parameter int WIDTH         = 32,
  parameter int INIT_CYCLES   = 2,
  parameter int SLICE_TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  tcam_add32_seq_ctrl_if.slave        bus,
  output logic                        busy,
  output logic                        tbl_wr_en,
  output logic                        slc_start,
  output logic [3:0]                  slc_a,
  output logic [3:0]                  slc_b,
  output logic [3:0]                  slc_c,
  input  logic                        slc_done,
  input  logic [5:0]                  slc_sum,
  output logic [2:0]                  dbg_state
);

  localparam int NSLC   = WIDTH / 4;
  localparam int IDX_W  = (NSLC > 1) ? $clog2(NSLC) : 1;
  localparam int INIT_W = (INIT_CYCLES > 0) ? $clog2(INIT_CYCLES + 1) : 1;
  localparam int TMR_W  = (SLICE_TIMEOUT > 1) ? $clog2(SLICE_TIMEOUT + 1) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NSLC - 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(SLICE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_INIT_WAIT = 3'd1,
    S_READY     = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT      = 3'd4,
    S_RESP      = 3'd5
  } state_t;

  state_t             state;
  logic [INIT_W-1:0]  init_cnt;
  logic [TMR_W-1:0]   tmr;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_nxt;
  logic               carry;
  logic               err;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   result;
  logic [WIDTH-1:0]   result_upd;

  assign busy      = (state != S_READY);
  assign dbg_state = state;

  // Result with the returning slice nibble merged in; used on the done edge.
  always_comb begin
    result_upd               = result;
    result_upd[4*idx +: 4]   = slc_sum[3:0];
    idx_nxt                  = idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_INIT;
      init_cnt      <= '0;
      tmr           <= '0;
      idx           <= '0;
      carry         <= 1'b0;
      err           <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      result        <= '0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_sum   <= '0;
      bus.rsp_cout  <= 1'b0;
      bus.rsp_err   <= 1'b0;
      tbl_wr_en     <= 1'b0;
      slc_start     <= 1'b0;
      slc_a         <= '0;
      slc_b         <= '0;
      slc_c         <= '0;
    end else begin
      tbl_wr_en <= 1'b0;
      slc_start <= 1'b0;
      case (state)
        S_INIT: begin
          tbl_wr_en <= 1'b1;
          init_cnt  <= '0;
          state     <= S_INIT_WAIT;
        end
        S_INIT_WAIT: begin
          if (init_cnt == INIT_LAST) begin
            bus.req_ready <= 1'b1;
            state         <= S_READY;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        S_READY: begin
          if (bus.req_valid && bus.req_ready) begin
            a_q           <= bus.req_a;
            b_q           <= bus.req_b;
            carry         <= bus.req_cin;
            idx           <= '0;
            result        <= '0;
            err           <= 1'b0;
            bus.req_ready <= 1'b0;
            slc_start     <= 1'b1;
            slc_a         <= bus.req_a[3:0];
            slc_b         <= bus.req_b[3:0];
            slc_c         <= {3'b000, bus.req_cin};
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmr   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving on the final timer cycle still counts.
          if (slc_done) begin
            result <= result_upd;
            carry  <= slc_sum[4];
            err    <= err | slc_sum[5];
            if (idx == IDX_LAST) begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_sum   <= result_upd;
              bus.rsp_cout  <= slc_sum[4];
              bus.rsp_err   <= err | slc_sum[5];
              state         <= S_RESP;
            end else begin
              idx       <= idx_nxt;
              slc_start <= 1'b1;
              slc_a     <= a_q[4*idx_nxt +: 4];
              slc_b     <= b_q[4*idx_nxt +: 4];
              slc_c     <= {3'b000, slc_sum[4]};
              state     <= S_ISSUE;
            end
          end else if (tmr == TMR_LAST) begin
            err           <= 1'b1;
            bus.rsp_valid <= 1'b1;
            bus.rsp_sum   <= result;
            bus.rsp_cout  <= carry;
            bus.rsp_err   <= 1'b1;
            state         <= S_RESP;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= S_READY;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule
